// File: rtl/fir_tap_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer_pkg
// Shared types and helpers for the FIR tap sequencer.
//   state_t  : sequencer state (IDLE waits for a sample, RUN emits a frame)
//   tap_addr : history index of sample x[n-k] in the circular buffer
// ---------------------------------------------------------------------------
package fir_tap_sequencer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // The newest sample lives at wr_ptr, so tap k looks k entries back.
   // A negative difference wraps by adding ntaps.
   function automatic int tap_addr(input int wr_ptr, input int k, input int ntaps);
      int idx;
      idx = wr_ptr - k;
      if (idx < 0) idx = idx + ntaps;
      return idx;
   endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer_if
// Bundles the streaming and coefficient-write signals of the sequencer.
//   s_axis_*  : input sample stream (tdata, tvalid, tready)
//   coef_wr_* : coefficient bank write port (en, addr, data)
//   m_axis_a* : sample output stream x[n-k] (tdata, tvalid, tready, tlast)
//   m_axis_b* : coefficient output stream c[k] (tdata, tvalid, tready, tlast)
// Modports:
//   master : the sequencer itself (drives s_axis_tready and the m_axis streams)
//   slave  : the surrounding environment (upstream source, MACC, software)
// ---------------------------------------------------------------------------
interface fir_tap_sequencer_if #(
   parameter int DW    = 24,
   parameter int CW    = 18,
   parameter int NTAPS = 16
);
   localparam int AW = $clog2(NTAPS);

   logic signed [DW-1:0] s_axis_tdata;
   logic                 s_axis_tvalid;
   logic                 s_axis_tready;

   logic                 coef_wr_en;
   logic [AW-1:0]        coef_wr_addr;
   logic signed [CW-1:0] coef_wr_data;

   logic signed [DW-1:0] m_axis_atdata;
   logic                 m_axis_atvalid;
   logic                 m_axis_atready;
   logic                 m_axis_atlast;

   logic signed [CW-1:0] m_axis_btdata;
   logic                 m_axis_btvalid;
   logic                 m_axis_btready;
   logic                 m_axis_btlast;

   modport master (
      input  s_axis_tdata, s_axis_tvalid,
      output s_axis_tready,
      input  coef_wr_en, coef_wr_addr, coef_wr_data,
      output m_axis_atdata, m_axis_atvalid, m_axis_atlast,
      input  m_axis_atready,
      output m_axis_btdata, m_axis_btvalid, m_axis_btlast,
      input  m_axis_btready
   );

   modport slave (
      output s_axis_tdata, s_axis_tvalid,
      input  s_axis_tready,
      output coef_wr_en, coef_wr_addr, coef_wr_data,
      input  m_axis_atdata, m_axis_atvalid, m_axis_atlast,
      output m_axis_atready,
      input  m_axis_btdata, m_axis_btvalid, m_axis_btlast,
      output m_axis_btready
   );
endinterface

// File: rtl/fir_tap_sequencer_chan.sv
// ---------------------------------------------------------------------------
// fir_tap_chan
// One output channel of the tap sequencer: tap counter, registered
// data/valid/last and a done flag for the current frame.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : load tap 0 on this edge (frame begins)
//   clear     : clear the done flag (frame ends)
//   tap_data  : data for the tap index presented on sel_k
//   sel_k     : tap index that will be loaded on the next load edge
//   ready     : downstream ready
//   data/valid/last : AXI-Stream output register
//   done      : last beat of this frame has been accepted
// ---------------------------------------------------------------------------
module fir_tap_chan
   import fir_tap_sequencer_pkg::*;
#(
   parameter  int W     = 24,
   parameter  int NTAPS = 16,
   localparam int AW    = $clog2(NTAPS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                clear,
   input  logic signed [W-1:0] tap_data,
   output logic [AW-1:0]       sel_k,
   input  logic                ready,
   output logic signed [W-1:0] data,
   output logic                valid,
   output logic                last,
   output logic                done
);

   logic [AW-1:0]       k_q, k_d;
   logic signed [W-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                done_q, done_d;
   logic                hs;

   assign hs    = valid_q & ready;
   assign sel_k = start ? '0 : k_q + AW'(1);

   // Register update: start loads tap 0; a handshake either loads the next
   // tap in the same edge (full throughput) or, on the last tap, drops valid
   // and marks the channel done until the frame is closed.
   always_comb begin
      k_d     = k_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = done_q;
      if (start) begin
         k_d     = '0;
         data_d  = tap_data;
         valid_d = 1'b1;
         last_d  = 1'b0;
      end else if (hs && !last_q) begin
         k_d    = sel_k;
         data_d = tap_data;
         last_d = (sel_k == AW'(NTAPS - 1));
      end else if (hs) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
         done_d  = 1'b1;
      end
      if (clear) done_d = 1'b0;
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         k_q     <= k_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign last  = last_q;
   assign done  = done_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
// Feeds a dual-stream MACC: for every accepted input sample it emits one
// frame of NTAPS (x[n-k], c[k]) pairs on two independent AXI-Stream outputs,
// tlast on tap NTAPS-1.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   flush : (only with FIR_TAP_SEQUENCER_FLUSH_EN) clears history in IDLE
//   bus   : fir_tap_sequencer_if.master (sample input, coefficient writes,
//           A and B output streams)
// Optional feature macro: FIR_TAP_SEQUENCER_FLUSH_EN
// ---------------------------------------------------------------------------
module fir_tap_sequencer
   import fir_tap_sequencer_pkg::*;
#(
   parameter  int DW    = 24,
   parameter  int CW    = 18,
   parameter  int NTAPS = 16,
   localparam int AW    = $clog2(NTAPS)
) (
   input  logic clk,
   input  logic rst,
`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
   input  logic flush,
`endif
   fir_tap_sequencer_if.master bus
);

   state_t               state_q, state_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic signed [DW-1:0] hist_q [NTAPS];
   logic signed [DW-1:0] hist_d [NTAPS];
   logic signed [CW-1:0] coef_q [NTAPS];
   logic signed [CW-1:0] coef_d [NTAPS];
   logic                 s_ready_q, s_ready_d;

   logic                 flush_in;
   logic                 s_ready;
   logic                 accept;
   logic                 start;
   logic                 clear;
   logic                 frame_end;

   logic [AW-1:0]        a_sel_k, b_sel_k;
   logic signed [DW-1:0] a_tap, a_data;
   logic signed [CW-1:0] b_tap, b_data;
   logic                 a_valid, a_last, a_done, a_fin;
   logic                 b_valid, b_last, b_done, b_fin;

`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
   assign flush_in = flush & (state_q == IDLE);
`else
   assign flush_in = 1'b0;
`endif

   // Ready is registered so it rises one edge after reset release; flush
   // masks it combinationally so a sample cannot slip in on a flush edge.
   assign s_ready   = s_ready_q & ~flush_in;
   assign accept    = bus.s_axis_tvalid & s_ready;
   assign a_fin     = a_valid & bus.m_axis_atready & a_last;
   assign b_fin     = b_valid & bus.m_axis_btready & b_last;
   assign frame_end = (a_done | a_fin) & (b_done | b_fin);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= s_ready_d;
      end
   end

   // Next state: a frame starts on an accepted sample and ends on the edge
   // where both channels have (or are just) finishing their last beat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (frame_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      start     = (state_q == IDLE) & accept;
      clear     = (state_q == RUN) & frame_end;
      s_ready_d = (state_d == IDLE);
   end

   // History, write pointer and coefficient bank. The pointer only advances
   // at frame end so every tap of the frame is addressed relative to the
   // sample that started it.
   always_comb begin
      hist_d   = hist_q;
      coef_d   = coef_q;
      wr_ptr_d = wr_ptr_q;
      if (flush_in) begin
         for (int i = 0; i < NTAPS; i++) hist_d[i] = '0;
         wr_ptr_d = '0;
      end else if (start) begin
         hist_d[wr_ptr_q] = bus.s_axis_tdata;
      end
      if (clear) wr_ptr_d = (wr_ptr_q == AW'(NTAPS - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (bus.coef_wr_en && (int'(bus.coef_wr_addr) < NTAPS))
         coef_d[bus.coef_wr_addr] = bus.coef_wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         for (int i = 0; i < NTAPS; i++) begin
            hist_q[i] <= '0;
            coef_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         hist_q   <= hist_d;
         coef_q   <= coef_d;
      end
   end

   // Tap data selection. Tap 0 comes straight from the input because the
   // history write happens on the same edge. Coefficients are read from the
   // registered bank, so a same-edge write is seen only by later loads.
   always_comb begin
      if (start) a_tap = bus.s_axis_tdata;
      else       a_tap = hist_q[AW'(tap_addr(int'(wr_ptr_q), int'(a_sel_k), NTAPS))];
      if (int'(b_sel_k) < NTAPS) b_tap = coef_q[b_sel_k];
      else                       b_tap = '0;
   end

   fir_tap_chan #(.W(DW), .NTAPS(NTAPS)) u_chan_a (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .clear    (clear),
      .tap_data (a_tap),
      .sel_k    (a_sel_k),
      .ready    (bus.m_axis_atready),
      .data     (a_data),
      .valid    (a_valid),
      .last     (a_last),
      .done     (a_done)
   );

   fir_tap_chan #(.W(CW), .NTAPS(NTAPS)) u_chan_b (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .clear    (clear),
      .tap_data (b_tap),
      .sel_k    (b_sel_k),
      .ready    (bus.m_axis_btready),
      .data     (b_data),
      .valid    (b_valid),
      .last     (b_last),
      .done     (b_done)
   );

   assign bus.s_axis_tready  = s_ready;
   assign bus.m_axis_atdata  = a_data;
   assign bus.m_axis_atvalid = a_valid;
   assign bus.m_axis_atlast  = a_last;
   assign bus.m_axis_btdata  = b_data;
   assign bus.m_axis_btvalid = b_valid;
   assign bus.m_axis_btlast  = b_last;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer
// Self-checking bench for fir_tap_sequencer with NTAPS=4: a table of frames
// with fixed expected taps, hand sequences for reset and flush, then random
// samples/back-pressure against a queue-based history model.
// ---------------------------------------------------------------------------
module tb_fir_tap_sequencer;

   localparam int DW = 24;
   localparam int CW = 18;
   localparam int NT = 4;

   logic clk;
   logic rst;
`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
   logic flush;
`endif

   fir_tap_sequencer_if #(.DW(DW), .CW(CW), .NTAPS(NT)) bus ();

   fir_tap_sequencer #(.DW(DW), .CW(CW), .NTAPS(NT)) dut (
      .clk   (clk),
`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
      .flush (flush),
`endif
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              smp;
      int              a_hb, a_hl, b_hb, b_hl;
      int              wb, wa, wd;
      logic [3:0][23:0] ea;
      logic [3:0][17:0] eb;
   } vec_t;

   vec_t vecs [9];

   int n_cmp = 0;
   int n_bad = 0;

   // frame knobs
   int a_hb, a_hl, b_hb, b_hl, wr_beat, wr_addr, wr_data, fl_beat;
   bit rand_rdy;

   logic signed [DW-1:0] exp_a [4];
   logic signed [CW-1:0] exp_b [4];

   // reference model: most recent samples first, plus the coefficient bank
   logic signed [DW-1:0] mdl_hist [$];
   logic signed [CW-1:0] mdl_coef [4];

   function automatic vec_t mk(input int smp, input int ahb, input int ahl, input int bhb,
                               input int bhl, input int wb, input int wa, input int wd,
                               input int a0, input int a1, input int a2, input int a3,
                               input int b0, input int b1, input int b2, input int b3);
      vec_t v;
      v.smp = smp; v.a_hb = ahb; v.a_hl = ahl; v.b_hb = bhb; v.b_hl = bhl;
      v.wb = wb; v.wa = wa; v.wd = wd;
      v.ea[0] = 24'(a0); v.ea[1] = 24'(a1); v.ea[2] = 24'(a2); v.ea[3] = 24'(a3);
      v.eb[0] = 18'(b0); v.eb[1] = 18'(b1); v.eb[2] = 18'(b2); v.eb[3] = 18'(b3);
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic clear_knobs();
      a_hb = -1; a_hl = 0; b_hb = -1; b_hl = 0;
      wr_beat = -1; wr_addr = 0; wr_data = 0; fl_beat = -1;
      rand_rdy = 1'b0;
   endtask

   task automatic model_frame(input int smp);
      mdl_hist.push_front(24'(smp));
      if (mdl_hist.size() > NT) void'(mdl_hist.pop_back());
      for (int k = 0; k < NT; k++) begin
         exp_a[k] = (k < mdl_hist.size()) ? mdl_hist[k] : '0;
         exp_b[k] = mdl_coef[k];
      end
   endtask

   task automatic write_coef(input int addr, input int data);
      bus.coef_wr_en   = 1'b1;
      bus.coef_wr_addr = 2'(addr);
      bus.coef_wr_data = 18'(data);
      @(posedge clk); #1;
      bus.coef_wr_en   = 1'b0;
      mdl_coef[addr]   = 18'(data);
   endtask

   // Offers one sample, then runs the frame under the current knobs,
   // checking both channels every cycle against exp_a/exp_b.
   task automatic apply_stimulus(input int smp);
      int   na, nb, t, aw, bw, a_need, b_need;
      logic ardy, brdy;
      bus.s_axis_tdata  = 24'(smp);
      bus.s_axis_tvalid = 1'b1;
      t = 0;
      while (bus.s_axis_tready !== 1'b1 && t < 20) begin
         @(posedge clk); #1; t++;
      end
      check_output("accept tready", 32'(bus.s_axis_tready), 32'd1);
      @(posedge clk); #1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      na = 0; nb = 0; t = 0; aw = 0; bw = 0;
      while ((na < NT || nb < NT) && t < 60) begin
         if (rand_rdy) begin
            ardy = ($urandom_range(0, 3) != 0);
            brdy = ($urandom_range(0, 3) != 0);
         end else begin
            ardy = !(na == a_hb && aw < a_hl);
            if (!ardy) aw++;
            brdy = !(nb == b_hb && bw < b_hl);
            if (!brdy) bw++;
         end
         bus.m_axis_atready = ardy;
         bus.m_axis_btready = brdy;
         bus.coef_wr_en     = (nb == wr_beat) && brdy;
         bus.coef_wr_addr   = 2'(wr_addr);
         bus.coef_wr_data   = 18'(wr_data);
`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
         flush = (na == fl_beat);
`endif
         #1;
         check_output("in-frame tready", 32'(bus.s_axis_tready), 32'd0);
         if (na < NT) begin
            check_output($sformatf("A%0d valid", na), 32'(bus.m_axis_atvalid), 32'd1);
            check_output($sformatf("A%0d data", na), 32'(bus.m_axis_atdata), 32'(exp_a[na]));
            check_output($sformatf("A%0d last", na), 32'(bus.m_axis_atlast), 32'(na == NT - 1));
         end else begin
            check_output("A idle valid", 32'(bus.m_axis_atvalid), 32'd0);
            check_output("A idle last", 32'(bus.m_axis_atlast), 32'd0);
         end
         if (nb < NT) begin
            check_output($sformatf("B%0d valid", nb), 32'(bus.m_axis_btvalid), 32'd1);
            check_output($sformatf("B%0d data", nb), 32'(bus.m_axis_btdata), 32'(exp_b[nb]));
            check_output($sformatf("B%0d last", nb), 32'(bus.m_axis_btlast), 32'(nb == NT - 1));
         end else begin
            check_output("B idle valid", 32'(bus.m_axis_btvalid), 32'd0);
            check_output("B idle last", 32'(bus.m_axis_btlast), 32'd0);
         end
         if (na < NT && bus.m_axis_atvalid && ardy) na++;
         if (nb < NT && bus.m_axis_btvalid && brdy) nb++;
         @(posedge clk); #1;
         t++;
      end
      bus.coef_wr_en = 1'b0;
`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
      flush = 1'b0;
`endif
      check_output("frame complete", 32'((na == NT) && (nb == NT)), 32'd1);
      if (!rand_rdy) begin
         a_need = NT + ((a_hb >= 0 && a_hb < NT) ? a_hl : 0);
         b_need = NT + ((b_hb >= 0 && b_hb < NT) ? b_hl : 0);
         check_output("frame cycles", 32'(t), 32'((a_need > b_need) ? a_need : b_need));
      end
      check_output("tready after frame", 32'(bus.s_axis_tready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clk = 1'b0;
      rst = 1'b0;
`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
      flush = 1'b0;
`endif
      bus.s_axis_tdata   = '0;
      bus.s_axis_tvalid  = 1'b0;
      bus.coef_wr_en     = 1'b0;
      bus.coef_wr_addr   = '0;
      bus.coef_wr_data   = '0;
      bus.m_axis_atready = 1'b1;
      bus.m_axis_btready = 1'b1;
      clear_knobs();
      for (int k = 0; k < NT; k++) mdl_coef[k] = '0;

      //              smp ahb ahl bhb bhl wb wa wd  A taps          B taps
      vecs[0] = mk(10, -1, 0, -1, 0, -1, 0, 0, 10, 0, 0, 0,   1, 2, 3, 4);
      vecs[1] = mk(20, -1, 0, -1, 0, -1, 0, 0, 20, 10, 0, 0,  1, 2, 3, 4);
      vecs[2] = mk(30, -1, 0, -1, 0, -1, 0, 0, 30, 20, 10, 0, 1, 2, 3, 4);
      vecs[3] = mk(40, -1, 0, -1, 0, -1, 0, 0, 40, 30, 20, 10, 1, 2, 3, 4);
      vecs[4] = mk(50, -1, 0, -1, 0, -1, 0, 0, 50, 40, 30, 20, 1, 2, 3, 4);
      vecs[5] = mk(60, 2, 3, -1, 0, -1, 0, 0,  60, 50, 40, 30, 1, 2, 3, 4);
      vecs[6] = mk(70, 3, 1, 0, 2, -1, 0, 0,   70, 60, 50, 40, 1, 2, 3, 4);
      vecs[7] = mk(80, -1, 0, -1, 0, 1, 2, 9,  80, 70, 60, 50, 1, 2, 3, 4);
      vecs[8] = mk(90, -1, 0, -1, 0, -1, 0, 0, 90, 80, 70, 60, 1, 2, 9, 4);

      // reset state
      #12;
      check_output("reset tready", 32'(bus.s_axis_tready), 32'd0);
      check_output("reset A valid", 32'(bus.m_axis_atvalid), 32'd0);
      check_output("reset B valid", 32'(bus.m_axis_btvalid), 32'd0);
      check_output("reset A last", 32'(bus.m_axis_atlast), 32'd0);
      check_output("reset B last", 32'(bus.m_axis_btlast), 32'd0);
      check_output("reset A data", 32'(bus.m_axis_atdata), 32'd0);
      check_output("reset B data", 32'(bus.m_axis_btdata), 32'd0);
      rst = 1'b1;
      #1;
      check_output("tready before first edge", 32'(bus.s_axis_tready), 32'd0);
      @(posedge clk); #1;
      check_output("tready after first edge", 32'(bus.s_axis_tready), 32'd1);

      for (int k = 0; k < NT; k++) write_coef(k, k + 1);

      $display("[TB] table-driven frames");
      for (int i = 0; i < 9; i++) begin
         model_frame(vecs[i].smp);
         for (int k = 0; k < NT; k++) begin
            exp_a[k] = vecs[i].ea[k];
            exp_b[k] = vecs[i].eb[k];
         end
         clear_knobs();
         a_hb = vecs[i].a_hb; a_hl = vecs[i].a_hl;
         b_hb = vecs[i].b_hb; b_hl = vecs[i].b_hl;
         wr_beat = vecs[i].wb; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
         apply_stimulus(vecs[i].smp);
         if (vecs[i].wb >= 0) mdl_coef[vecs[i].wa] = 18'(vecs[i].wd);
      end

      // coefficient written in IDLE shows up in the next frame
      clear_knobs();
      write_coef(0, 5);
      model_frame(100);
      apply_stimulus(100);

      // reset in the middle of a frame
      $display("[TB] reset mid-frame");
      bus.s_axis_tdata  = 24'd111;
      bus.s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
      bus.s_axis_tvalid = 1'b0;
      bus.m_axis_atready = 1'b1;
      bus.m_axis_btready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check_output("midrst A valid", 32'(bus.m_axis_atvalid), 32'd0);
      check_output("midrst B valid", 32'(bus.m_axis_btvalid), 32'd0);
      check_output("midrst A last", 32'(bus.m_axis_atlast), 32'd0);
      check_output("midrst tready", 32'(bus.s_axis_tready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      mdl_hist.delete();
      for (int k = 0; k < NT; k++) mdl_coef[k] = '0;
      @(posedge clk); #1;
      model_frame(7);
      exp_a[0] = 24'd7; exp_a[1] = '0; exp_a[2] = '0; exp_a[3] = '0;
      for (int k = 0; k < NT; k++) exp_b[k] = '0;
      apply_stimulus(7);

      // random samples, back-pressure and IDLE coefficient writes
      $display("[TB] random frames");
      for (int k = 0; k < NT; k++) write_coef(k, int'($urandom_range(0, 262143)));
      for (int i = 0; i < 40; i++) begin
         int smp;
         clear_knobs();
         rand_rdy = 1'b1;
         if ($urandom_range(0, 3) == 0)
            write_coef(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 262143)));
         smp = int'($urandom_range(0, 16777215));
         model_frame(smp);
         apply_stimulus(smp);
      end

`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
      $display("[TB] flush");
      clear_knobs();
      model_frame(10); apply_stimulus(10);
      model_frame(20); apply_stimulus(20);
      flush = 1'b1;
      bus.s_axis_tdata  = 24'd99;
      bus.s_axis_tvalid = 1'b1;
      #1;
      check_output("flush blocks tready", 32'(bus.s_axis_tready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      mdl_hist.delete();
      model_frame(5);
      check_output("model flush tap1", 32'(exp_a[1]), 32'd0);
      apply_stimulus(5);
      fl_beat = 1;
      model_frame(6); apply_stimulus(6);
      clear_knobs();
      model_frame(8); apply_stimulus(8);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
